// File: rtl/clk_en_gen_pkg.sv
// Shared types and defaults for the fractional clock-enable generator.
// Channel config fields are sized to ACC_W_MAX; instances use the low ACC_W bits.
package clk_en_gen_pkg;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_ACC_W       = 16;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int ACC_W_MAX       = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [ACC_W_MAX-1:0] mul;
        logic [ACC_W_MAX-1:0] div;
        logic [ACC_W_MAX-1:0] phase;
    } ch_cfg_t;

endpackage

// File: rtl/clk_en_gen_if.sv
// Config request channel: valid/ready handshake plus a one-cycle reject flag.
// cfg_err returns one cycle after a rejected handshake.
interface clk_en_gen_if
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ACC_W  = DEF_ACC_W
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_mul;
    logic [ACC_W-1:0] cfg_div;
    logic [ACC_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mul, cfg_div, cfg_phase,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mul, cfg_div, cfg_phase,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_en_gen_ch.sv
// One fractional accumulator channel: pulse rate mul/div of refclk, pulse registered.
// A load replaces mul/div/acc at that edge and suppresses the pulse for one cycle.
module clk_en_gen_ch
    import clk_en_gen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic    refclk,
    input  logic    rst,
    input  logic    load,
    input  ch_cfg_t cfg,
    output logic    pulse
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] mul_q;
    logic [ACC_W-1:0] div_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, mul_q};

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_q <= '0;
            mul_q <= '0;
            div_q <= ACC_W'(1);
            pulse <= 1'b0;
        end else if (load) begin
            acc_q <= cfg.phase[ACC_W-1:0];
            mul_q <= cfg.mul[ACC_W-1:0];
            div_q <= cfg.div[ACC_W-1:0];
            pulse <= 1'b0;
        end else if (sum >= {1'b0, div_q}) begin
            acc_q <= ACC_W'(sum - {1'b0, div_q});
            pulse <= 1'b1;
        end else begin
            acc_q <= sum[ACC_W-1:0];
            pulse <= 1'b0;
        end
    end

    // Upper struct bits are zero-extension padding for narrow instances.
    if (ACC_W < ACC_W_MAX) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{cfg.mul[ACC_W_MAX-1:ACC_W], cfg.div[ACC_W_MAX-1:ACC_W],
                             cfg.phase[ACC_W_MAX-1:ACC_W]};
    end

endmodule

// File: rtl/clk_en_gen.sv
// NUM_CH fractional clock-enable channels with validated config and a settle/lock FSM.
// Optional CLKGEN_PHASE_EN loads and range-checks cfg_phase; cfg_ready drops only in LOAD.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic              refclk,
    input  logic              rst,
    clk_en_gen_if.slave       cfg,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;
    logic             ready;
    logic             hs;
    logic             bad;
    logic             ch_bad;
    logic             phase_bad;
    logic             accept;
    logic [ACC_W-1:0] load_phase;
    ch_cfg_t          load_cfg;
    logic [NUM_CH-1:0] pulse;

`ifdef CLKGEN_PHASE_EN
    assign load_phase = cfg.cfg_phase;
    assign phase_bad  = (cfg.cfg_phase >= cfg.cfg_div);
`else
    logic unused_phase;
    assign unused_phase = ^cfg.cfg_phase;
    assign load_phase   = '0;
    assign phase_bad    = 1'b0;
`endif

    assign ready  = (state_q != LOAD);
    assign hs     = cfg.cfg_valid && ready;
    assign ch_bad = ({1'b0, cfg.cfg_ch} >= (CH_W+1)'(NUM_CH));
    assign bad    = (cfg.cfg_div == '0) || (cfg.cfg_mul > cfg.cfg_div) || ch_bad || phase_bad;
    assign accept = hs && !bad;

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;
    assign locked        = (state_q == LOCKED);
    assign outclk_en     = pulse & ch_en;

    always_comb begin
        load_cfg       = '0;
        load_cfg.mul   = ACC_W_MAX'(cfg.cfg_mul);
        load_cfg.div   = ACC_W_MAX'(cfg.cfg_div);
        load_cfg.phase = ACC_W_MAX'(load_phase);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= hs && bad;
        end
    end

    // Any accepted config restarts the settle window, even from LOCKED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (accept)                 state_d = LOAD;
                else if (cnt_q == CNT_LAST) state_d = LOCKED;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            LOCKED:  if (accept) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_gen_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .refclk (refclk),
            .rst    (rst),
            .load   (accept && (cfg.cfg_ch == CH_W'(i))),
            .cfg    (load_cfg),
            .pulse  (pulse[i])
        );
    end

endmodule
